// File: rtl/prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// prescaled_updown_counter
//
// General-purpose WIDTH-bit up/down timer/event counter with a programmable
// prescaler and a programmable top value. The count range is 0..limit_i.
// At a bound the counter either wraps (SATURATE=0) or holds (SATURATE=1),
// reporting each arrival at the terminal condition with a one-cycle tc_o pulse.
//
// Parameters
//   WIDTH       counter width in bits (2..32)
//   PRESCALE_W  prescaler width; divide ratio is prescale_i+1 (1..2^PRESCALE_W)
//   SATURATE    0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports
//   clk_i       clock, all state updates on the rising edge
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear (highest synchronous priority)
//   load_i      synchronous load of min(load_val_i, limit_i)
//   load_val_i  load value
//   en_i        count enable, gates the prescaler
//   up_i        1 = count up, 0 = count down (sampled on each tick)
//   limit_i     top value of the count range
//   prescale_i  divide ratio minus 1
//   count_o     current count (registered)
//   tick_o      combinational, high in any cycle where a count step occurs
//   tc_o        registered one-cycle terminal-count pulse
//   sat_o       registered, high while held at a bound (SATURATE=1 only)
// -----------------------------------------------------------------------------
module prescaled_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4,
    parameter int SATURATE   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  tick_o,
    output logic                  tc_o,
    output logic                  sat_o
);

    localparam logic [WIDTH-1:0]      CNT_ZERO = '0;
    localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PSC_ZERO = '0;
    localparam logic [PRESCALE_W-1:0] PSC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    // State
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] psc_q,   psc_d;
    logic                  tc_q,    tc_d;
    logic                  sat_q,   sat_d;

    // Datapath helpers
    logic                  tick;
    logic                  term_up;
    logic                  term_dn;
    logic                  term;
    logic [WIDTH-1:0]      load_clamped;
    logic [WIDTH-1:0]      count_step;
    logic [WIDTH-1:0]      count_bound;

    // A tick is suppressed by clear or load so that those operations never
    // race with a count step in the same cycle.
    assign tick = en_i && (psc_q == prescale_i) && !clr_i && !load_i;

    // Up-terminal uses >= so that a limit lowered below the current count is
    // caught on the next tick instead of counting up to 2^WIDTH-1.
    assign term_up = (count_q >= limit_i);
    assign term_dn = (count_q == CNT_ZERO);
    assign term    = up_i ? term_up : term_dn;

    assign load_clamped = (load_val_i > limit_i) ? limit_i : load_val_i;

    // Non-terminal step: cannot overflow because term_up intercepts
    // count_q >= limit_i (which includes 2^WIDTH-1) and term_dn intercepts 0.
    assign count_step = up_i ? (count_q + CNT_ONE) : (count_q - CNT_ONE);

    // Value reached on a terminal tick. Wrapping goes to the opposite bound,
    // saturating clamps to the bound being approached.
    generate
        if (SATURATE != 0) begin : g_bound_sat
            assign count_bound = up_i ? limit_i : CNT_ZERO;
        end else begin : g_bound_wrap
            assign count_bound = up_i ? CNT_ZERO : limit_i;
        end
    endgenerate

    // Next-state logic
    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        tc_d    = 1'b0;     // tc is a pulse: any non-qualifying cycle clears it
        sat_d   = sat_q;    // sat holds across idle cycles

        if (clr_i) begin
            count_d = CNT_ZERO;
            psc_d   = PSC_ZERO;
            sat_d   = 1'b0;
        end else if (load_i) begin
            count_d = load_clamped;
            psc_d   = PSC_ZERO;
            sat_d   = 1'b0;
        end else if (en_i) begin
            if (tick) begin
                psc_d = PSC_ZERO;
                if (!term) begin
                    count_d = count_step;
                    sat_d   = 1'b0;
                end else if (SATURATE != 0) begin
                    count_d = count_bound;
                    // Only the first arrival at the bound is reported.
                    tc_d    = !sat_q;
                    sat_d   = 1'b1;
                end else begin
                    count_d = count_bound;
                    tc_d    = 1'b1;
                    sat_d   = 1'b0;
                end
            end else begin
                // If prescale_i was lowered below psc_q, psc wraps through
                // its maximum before matching again; that is accepted.
                psc_d = psc_q + PSC_ONE;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= CNT_ZERO;
            psc_q   <= PSC_ZERO;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign tick_o  = tick;
    assign tc_o    = tc_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// -----------------------------------------------------------------------------
// Testbench for prescaled_updown_counter. Two instances share all stimulus:
// one built to wrap, one built to saturate. A behavioural reference model
// produces the expected state for each clock edge; expectations are pushed to
// a queue when stimulus is applied and popped when the edge has been taken.
// -----------------------------------------------------------------------------
module tb_prescaled_updown_counter;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          load;
    logic [W-1:0]  load_val;
    logic          en;
    logic          up;
    logic [W-1:0]  limit;
    logic [PW-1:0] prescale;

    logic [W-1:0]  count_w, count_s;
    logic          tick_w, tick_s, tc_w, tc_s, sat_w, sat_s;

    int n_cmp = 0;
    int n_bad = 0;

    prescaled_updown_counter #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(0)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load),
        .load_val_i(load_val), .en_i(en), .up_i(up), .limit_i(limit),
        .prescale_i(prescale), .count_o(count_w), .tick_o(tick_w),
        .tc_o(tc_w), .sat_o(sat_w)
    );

    prescaled_updown_counter #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load),
        .load_val_i(load_val), .en_i(en), .up_i(up), .limit_i(limit),
        .prescale_i(prescale), .count_o(count_s), .tick_o(tick_s),
        .tc_o(tc_s), .sat_o(sat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = wrap instance, 1 = saturate instance
    logic [W-1:0]  m_cnt [2];
    logic [PW-1:0] m_psc [2];
    logic          m_tc  [2];
    logic          m_sat [2];

    typedef struct packed {
        logic [W-1:0] cnt_w;
        logic [W-1:0] cnt_s;
        logic         tc_w;
        logic         tc_s;
        logic         sat_w;
        logic         sat_s;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = '0;
            m_psc[i] = '0;
            m_tc[i]  = 1'b0;
            m_sat[i] = 1'b0;
        end
    endtask

    // One clock cycle: inputs are already applied. Check tick_o before the
    // edge, advance the model, push expectation, take the edge, pop and check.
    task automatic step(input string tag);
        exp_t   e;
        exp_t   got;
        logic   mtick;
        logic   term;
        #2;
        for (int i = 0; i < 2; i++) begin
            mtick = en && (m_psc[i] == prescale) && !clr && !load;
            if (i == 0) chk({tag, " tick_w"}, {31'd0, tick_w}, {31'd0, mtick});
            else        chk({tag, " tick_s"}, {31'd0, tick_s}, {31'd0, mtick});
            if (clr) begin
                m_cnt[i] = '0; m_psc[i] = '0; m_tc[i] = 1'b0; m_sat[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (load_val > limit) ? limit : load_val;
                m_psc[i] = '0; m_tc[i] = 1'b0; m_sat[i] = 1'b0;
            end else if (!en) begin
                m_tc[i] = 1'b0;
            end else if (!mtick) begin
                m_psc[i] = m_psc[i] + 4'd1;
                m_tc[i]  = 1'b0;
            end else begin
                m_psc[i] = '0;
                term = up ? (m_cnt[i] >= limit) : (m_cnt[i] == 8'd0);
                if (!term) begin
                    m_cnt[i] = up ? m_cnt[i] + 8'd1 : m_cnt[i] - 8'd1;
                    m_tc[i]  = 1'b0;
                    m_sat[i] = 1'b0;
                end else if (i == 0) begin
                    m_cnt[i] = up ? 8'd0 : limit;
                    m_tc[i]  = 1'b1;
                    m_sat[i] = 1'b0;
                end else begin
                    m_cnt[i] = up ? limit : 8'd0;
                    m_tc[i]  = !m_sat[i];
                    m_sat[i] = 1'b1;
                end
            end
        end
        e.cnt_w = m_cnt[0]; e.cnt_s = m_cnt[1];
        e.tc_w  = m_tc[0];  e.tc_s  = m_tc[1];
        e.sat_w = m_sat[0]; e.sat_s = m_sat[1];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, " count_w"}, {24'd0, count_w}, {24'd0, got.cnt_w});
        chk({tag, " count_s"}, {24'd0, count_s}, {24'd0, got.cnt_s});
        chk({tag, " tc_w"},    {31'd0, tc_w},    {31'd0, got.tc_w});
        chk({tag, " tc_s"},    {31'd0, tc_s},    {31'd0, got.tc_s});
        chk({tag, " sat_w"},   {31'd0, sat_w},   {31'd0, got.sat_w});
        chk({tag, " sat_s"},   {31'd0, sat_s},   {31'd0, got.sat_s});
        $display("step %-10s clr=%0b load=%0b en=%0b up=%0b lim=%0d psc_in=%0d | cnt_w=%0d tc_w=%0b | cnt_s=%0d tc_s=%0b sat_s=%0b",
                 tag, clr, load, en, up, limit, prescale, count_w, tc_w, count_s, tc_s, sat_s);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        en = 1'b0; up = 1'b1; limit = 8'd255; prescale = '0;
        model_reset();
        #1;
        chk("rst count_w", {24'd0, count_w}, 32'd0);
        chk("rst count_s", {24'd0, count_s}, 32'd0);
        chk("rst tc_w",    {31'd0, tc_w},    32'd0);
        chk("rst sat_s",   {31'd0, sat_s},   32'd0);
        chk("rst tick_w",  {31'd0, tick_w},  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1. Count with prescale 0, asynchronous reset mid-run, prescale 3
        en = 1'b1; up = 1'b1; limit = 8'd255; prescale = 4'd0;
        for (int k = 0; k < 3; k++) step("run");
        chk("run3 count_w", {24'd0, count_w}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("async count_w", {24'd0, count_w}, 32'd0);
        chk("async count_s", {24'd0, count_s}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        chk("rsthold count_w", {24'd0, count_w}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step("resume");
        chk("resume count_w", {24'd0, count_w}, 32'd3);
        prescale = 4'd3;
        for (int k = 0; k < 8; k++) step("psc3");
        chk("psc3 count_w", {24'd0, count_w}, 32'd5);

        // 2. Wrap up at limit 9, then wrap down from 0
        prescale = 4'd0; clr = 1'b1; step("clr"); clr = 1'b0;
        limit = 8'd9;
        for (int k = 0; k < 10; k++) step("wrapup");
        chk("wrapup count_w", {24'd0, count_w}, 32'd0);
        chk("wrapup tc_w",    {31'd0, tc_w},    32'd1);
        chk("wrapup count_s", {24'd0, count_s}, 32'd9);
        chk("wrapup sat_s",   {31'd0, sat_s},   32'd1);
        step("after");
        chk("after tc_w", {31'd0, tc_w}, 32'd0);
        chk("after tc_s", {31'd0, tc_s}, 32'd0);
        clr = 1'b1; step("clr"); clr = 1'b0;
        up = 1'b0; step("wrapdn");
        chk("wrapdn count_w", {24'd0, count_w}, 32'd9);
        chk("wrapdn tc_w",    {31'd0, tc_w},    32'd1);
        chk("wrapdn count_s", {24'd0, count_s}, 32'd0);

        // 3. Saturation at limit 5 from 3, then reverse
        up = 1'b1; limit = 8'd5; load = 1'b1; load_val = 8'd3; step("ld3"); load = 1'b0;
        for (int k = 0; k < 4; k++) step("satup");
        chk("satup count_s", {24'd0, count_s}, 32'd5);
        chk("satup sat_s",   {31'd0, sat_s},   32'd1);
        chk("satup tc_s",    {31'd0, tc_s},    32'd0);
        up = 1'b0; step("satrev");
        chk("satrev count_s", {24'd0, count_s}, 32'd4);
        chk("satrev sat_s",   {31'd0, sat_s},   32'd0);

        // 4. Load clamp and priority
        limit = 8'd100; load = 1'b1; load_val = 8'd200; step("ldclamp");
        chk("ldclamp count_w", {24'd0, count_w}, 32'd100);
        clr = 1'b1; load_val = 8'd50; step("clrld"); clr = 1'b0;
        chk("clrld count_w", {24'd0, count_w}, 32'd0);
        load_val = 8'd7; step("ldtick"); load = 1'b0;
        chk("ldtick count_w", {24'd0, count_w}, 32'd7);
        chk("ldtick tc_w",    {31'd0, tc_w},    32'd0);

        // 5. Limit lowered below the count
        load = 1'b1; load_val = 8'd50; step("ld50"); load = 1'b0;
        up = 1'b1; limit = 8'd20; step("limlow");
        chk("limlow count_w", {24'd0, count_w}, 32'd0);
        chk("limlow tc_w",    {31'd0, tc_w},    32'd1);
        chk("limlow count_s", {24'd0, count_s}, 32'd20);
        chk("limlow sat_s",   {31'd0, sat_s},   32'd1);

        // limit 0: every tick is terminal
        clr = 1'b1; step("clr"); clr = 1'b0;
        limit = 8'd0;
        for (int k = 0; k < 2; k++) step("lim0");
        chk("lim0 count_w", {24'd0, count_w}, 32'd0);
        chk("lim0 tc_w",    {31'd0, tc_w},    32'd1);

        // 6. Enable gating with prescale 2
        clr = 1'b1; step("clr"); clr = 1'b0;
        limit = 8'd100; prescale = 4'd2; en = 1'b1;
        step("en1");
        en = 1'b0;
        for (int k = 0; k < 5; k++) step("gated");
        chk("gated count_w", {24'd0, count_w}, 32'd0);
        en = 1'b1;
        step("reen");
        chk("reen count_w", {24'd0, count_w}, 32'd0);
        step("reen_tick");
        chk("reen_tick count_w", {24'd0, count_w}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
